// File: rtl/rtc_cal_pkg.sv
// Shared types and constants for the RTC calendar engine: packed calendar
// record, field widths, field limits and the load FSM state encoding.
package rtc_cal_pkg;

    localparam int RTC_CAL_SEC_W  = 6;
    localparam int RTC_CAL_MIN_W  = 6;
    localparam int RTC_CAL_HOUR_W = 5;
    localparam int RTC_CAL_DAY_W  = 5;
    localparam int RTC_CAL_WDAY_W = 3;
    localparam int RTC_CAL_MON_W  = 4;
    localparam int RTC_CAL_YEAR_W = 7;

    localparam logic [RTC_CAL_SEC_W-1:0]  RTC_CAL_SEC_MAX  = 6'd59;
    localparam logic [RTC_CAL_MIN_W-1:0]  RTC_CAL_MIN_MAX  = 6'd59;
    localparam logic [RTC_CAL_HOUR_W-1:0] RTC_CAL_HOUR_MAX = 5'd23;
    localparam logic [RTC_CAL_MON_W-1:0]  RTC_CAL_MON_MAX  = 4'd12;
    localparam logic [RTC_CAL_WDAY_W-1:0] RTC_CAL_WDAY_MAX = 3'd6;

    // Packed so that sec sits in bits [5:0] and year in bits [35:29].
    typedef struct packed {
        logic [RTC_CAL_YEAR_W-1:0] year;
        logic [RTC_CAL_MON_W-1:0]  mon;
        logic [RTC_CAL_WDAY_W-1:0] wday;
        logic [RTC_CAL_DAY_W-1:0]  day;
        logic [RTC_CAL_HOUR_W-1:0] hour;
        logic [RTC_CAL_MIN_W-1:0]  min;
        logic [RTC_CAL_SEC_W-1:0]  sec;
    } rtc_time_t;

    typedef enum logic [1:0] {
        LD_IDLE   = 2'd0,
        LD_CHECK  = 2'd1,
        LD_COMMIT = 2'd2
    } rtc_cal_ld_state_e;

endpackage

// File: rtl/rtc_cal_mdays.sv
// Days-in-month lookup for a month/year-offset pair. Years 2000-2099 are
// leap exactly when the offset is a multiple of four. Out-of-range months
// report 31; callers reject such months separately.
module rtc_cal_mdays
    import rtc_cal_pkg::*;
(
    input  logic [RTC_CAL_MON_W-1:0]  mon_i,
    input  logic [RTC_CAL_YEAR_W-1:0] year_i,
    output logic [RTC_CAL_DAY_W-1:0]  mdays_o
);

    // Only the two low year bits decide leap years in this century.
    logic unused_year_hi;
    assign unused_year_hi = ^year_i[RTC_CAL_YEAR_W-1:2];

    // Month length table.
    always_comb begin
        case (mon_i)
            4'd2:                    mdays_o = (year_i[1:0] == 2'b00) ? 5'd29 : 5'd28;
            4'd4, 4'd6, 4'd9, 4'd11: mdays_o = 5'd30;
            default:                 mdays_o = 5'd31;
        endcase
    end

endmodule

// File: rtl/rtc_calendar.sv
// Second-resolution calendar (2000-2099) advanced by a one-cycle tick, with a
// three-stage validated load path (IDLE -> CHECK -> COMMIT) and an optional
// masked alarm compare enabled by the RTC_CAL_ALRM_EN macro. Without the
// macro, alrm_o is tied low and the alarm inputs are unused.
module rtc_calendar
    import rtc_cal_pkg::*;
#(
    parameter int unsigned YEAR_MAX = 99,
    parameter int unsigned RST_WDAY = 6
) (
    input  logic        rtc_clk_i,
    input  logic        rtc_rst_n_i,
    input  logic        en_i,
    input  logic        tick_i,
    input  logic        ld_valid_i,
    output logic        ld_ready_o,
    input  logic [35:0] ld_time_i,
    output logic [35:0] time_o,
    output logic        ld_err_o,
    output logic        ovf_o,
    input  logic [35:0] alrm_time_i,
    input  logic [4:0]  alrm_msk_i,
    output logic        alrm_o
);

    localparam logic [RTC_CAL_YEAR_W-1:0] YEAR_MAX_L = RTC_CAL_YEAR_W'(YEAR_MAX);
    localparam logic [RTC_CAL_WDAY_W-1:0] RST_WDAY_L = RTC_CAL_WDAY_W'(RST_WDAY);
    localparam rtc_time_t RST_TIME = '{year: '0, mon: 4'd1, wday: RST_WDAY_L,
                                       day: 5'd1, hour: '0, min: '0, sec: '0};

    rtc_cal_ld_state_e state_q, state_d;
    rtc_time_t         time_q, time_d;
    rtc_time_t         ld_q, ld_d;
    logic              valid_q, valid_d;
    logic              pend_q, pend_d;
    logic              ld_err_q, ld_err_d;
    logic              ovf_q, ovf_d;
    logic              wr_d;

    rtc_time_t                inc_time;
    logic                     inc_wrap;
    logic                     ld_ok;
    logic                     tick_en;
    logic [RTC_CAL_DAY_W-1:0] mdays_inc;
    logic [RTC_CAL_DAY_W-1:0] mdays_ld;

    assign tick_en = en_i & tick_i;

    rtc_cal_mdays u_mdays_inc (
        .mon_i   (time_q.mon),
        .year_i  (time_q.year),
        .mdays_o (mdays_inc)
    );

    rtc_cal_mdays u_mdays_ld (
        .mon_i   (ld_q.mon),
        .year_i  (ld_q.year),
        .mdays_o (mdays_ld)
    );

    // Full one-second carry chain from the current calendar, resolved in one cycle.
    always_comb begin
        inc_time = time_q;
        inc_wrap = 1'b0;
        if (time_q.sec < RTC_CAL_SEC_MAX) begin
            inc_time.sec = time_q.sec + 6'd1;
        end else begin
            inc_time.sec = '0;
            if (time_q.min < RTC_CAL_MIN_MAX) begin
                inc_time.min = time_q.min + 6'd1;
            end else begin
                inc_time.min = '0;
                if (time_q.hour < RTC_CAL_HOUR_MAX) begin
                    inc_time.hour = time_q.hour + 5'd1;
                end else begin
                    inc_time.hour = '0;
                    inc_time.wday = (time_q.wday >= RTC_CAL_WDAY_MAX) ? 3'd0 : time_q.wday + 3'd1;
                    if (time_q.day < mdays_inc) begin
                        inc_time.day = time_q.day + 5'd1;
                    end else begin
                        inc_time.day = 5'd1;
                        if (time_q.mon < RTC_CAL_MON_MAX) begin
                            inc_time.mon = time_q.mon + 4'd1;
                        end else begin
                            inc_time.mon = 4'd1;
                            if (time_q.year < YEAR_MAX_L) begin
                                inc_time.year = time_q.year + 7'd1;
                            end else begin
                                inc_time.year = '0;
                                inc_wrap      = 1'b1;
                            end
                        end
                    end
                end
            end
        end
    end

    // Range check of the captured load word.
    always_comb begin
        ld_ok = (ld_q.sec  <= RTC_CAL_SEC_MAX)  &&
                (ld_q.min  <= RTC_CAL_MIN_MAX)  &&
                (ld_q.hour <= RTC_CAL_HOUR_MAX) &&
                (ld_q.mon  >= 4'd1) && (ld_q.mon <= RTC_CAL_MON_MAX) &&
                (ld_q.day  >= 5'd1) && (ld_q.day <= mdays_ld) &&
                (ld_q.wday <= RTC_CAL_WDAY_MAX) &&
                (ld_q.year <= YEAR_MAX_L);
    end

    // Load FSM and calendar next-state. A tick seen while a load is in flight
    // is held in pend; it only survives if the load is rejected.
    always_comb begin
        state_d  = state_q;
        time_d   = time_q;
        ld_d     = ld_q;
        valid_d  = valid_q;
        pend_d   = pend_q;
        ld_err_d = 1'b0;
        ovf_d    = 1'b0;
        wr_d     = 1'b0;
        case (state_q)
            LD_IDLE: begin
                if (tick_en) begin
                    time_d = inc_time;
                    ovf_d  = inc_wrap;
                    wr_d   = 1'b1;
                end
                if (ld_valid_i) begin
                    ld_d    = ld_time_i;
                    pend_d  = 1'b0;
                    state_d = LD_CHECK;
                end
            end
            LD_CHECK: begin
                valid_d = ld_ok;
                if (tick_en) begin
                    pend_d = 1'b1;
                end
                state_d = LD_COMMIT;
            end
            LD_COMMIT: begin
                pend_d  = 1'b0;
                state_d = LD_IDLE;
                if (valid_q) begin
                    time_d = ld_q;
                    wr_d   = 1'b1;
                end else begin
                    ld_err_d = 1'b1;
                    if (pend_q || tick_en) begin
                        time_d = inc_time;
                        ovf_d  = inc_wrap;
                        wr_d   = 1'b1;
                    end
                end
            end
            default: begin
                state_d = LD_IDLE;
            end
        endcase
    end

    // Calendar, load pipeline and status pulse registers.
    always_ff @(posedge rtc_clk_i or negedge rtc_rst_n_i) begin
        if (!rtc_rst_n_i) begin
            state_q  <= LD_IDLE;
            time_q   <= RST_TIME;
            ld_q     <= '0;
            valid_q  <= 1'b0;
            pend_q   <= 1'b0;
            ld_err_q <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            time_q   <= time_d;
            ld_q     <= ld_d;
            valid_q  <= valid_d;
            pend_q   <= pend_d;
            ld_err_q <= ld_err_d;
            ovf_q    <= ovf_d;
        end
    end

    assign ld_ready_o = (state_q == LD_IDLE);
    assign time_o     = time_q;
    assign ld_err_o   = ld_err_q;
    assign ovf_o      = ovf_q;

`ifdef RTC_CAL_ALRM_EN
    rtc_time_t alrm_t;
    logic      wr_q;
    logic      alrm_q, alrm_d;
    logic      unused_alrm;

    assign alrm_t      = alrm_time_i;
    assign unused_alrm = ^{alrm_t.wday, alrm_t.year};

    // Compare the freshly written calendar against the enabled alarm fields.
    always_comb begin
        alrm_d = wr_q && (alrm_msk_i != 5'd0) &&
                 (!alrm_msk_i[0] || (time_q.sec  == alrm_t.sec))  &&
                 (!alrm_msk_i[1] || (time_q.min  == alrm_t.min))  &&
                 (!alrm_msk_i[2] || (time_q.hour == alrm_t.hour)) &&
                 (!alrm_msk_i[3] || (time_q.day  == alrm_t.day))  &&
                 (!alrm_msk_i[4] || (time_q.mon  == alrm_t.mon));
    end

    // Write marker and registered alarm pulse.
    always_ff @(posedge rtc_clk_i or negedge rtc_rst_n_i) begin
        if (!rtc_rst_n_i) begin
            wr_q   <= 1'b0;
            alrm_q <= 1'b0;
        end else begin
            wr_q   <= wr_d;
            alrm_q <= alrm_d;
        end
    end

    assign alrm_o = alrm_q;
`else
    logic unused_alrm;
    assign unused_alrm = ^{alrm_time_i, alrm_msk_i, wr_d};
    assign alrm_o      = 1'b0;
`endif

endmodule
